// File: rtl/day3_pkg.sv
// Shared constants and types for the day-3 bank feeder.
// Covers the digit width, the ASCII codes the parser recognises, and the feeder sequencing states.
package day3_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CLR    = 3'd1,
        ST_PLAY   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } feeder_state_t;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

endpackage

// File: rtl/day3_digit_buffer.sv
// Column-major digit store: one word per column holds that column's digit for every row.
// Reading a word therefore yields one digit per lane, which performs the row-to-lane transpose.
module day3_digit_buffer
    import day3_pkg::*;
#(
    parameter int NUM_UNITS = 200,
    parameter int LINE_LEN  = 100,
    parameter int LEN_W     = $clog2(LINE_LEN + 1),
    parameter int ROW_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic [LEN_W-1:0]             wr_col,
    input  logic [ROW_W-1:0]             wr_row,
    input  logic [DIGIT_W-1:0]           wr_digit,
    input  logic [LEN_W-1:0]             rd_addr,
    output logic [NUM_UNITS*DIGIT_W-1:0] rd_data
);

    localparam int WORD_W = NUM_UNITS * DIGIT_W;
    localparam int ADDR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [LEN_W-1:0] DEPTH_C = LEN_W'(LINE_LEN);

    logic [WORD_W-1:0] mem_r [LINE_LEN];

    // Nibble write of one parsed digit into its column word
    always_ff @(posedge clock) begin
        if (wr_en && (wr_col < DEPTH_C)) begin
            mem_r[wr_col[ADDR_W-1:0]][wr_row*DIGIT_W +: DIGIT_W] <= wr_digit;
        end
    end

    // Registered full-word read; out-of-range addresses return zero
    always_ff @(posedge clock) begin
        if (rd_addr < DEPTH_C) begin
            rd_data <= mem_r[rd_addr[ADDR_W-1:0]];
        end else begin
            rd_data <= {WORD_W{1'b0}};
        end
    end

endmodule

// File: rtl/day3_bank_feeder.sv
// Parses ASCII battery banks into a transposing buffer, then plays columns out in lockstep
// to the per-lane joltage units, sequencing their clear, flush and settle.
module day3_bank_feeder
    import day3_pkg::*;
#(
    parameter int NUM_UNITS = 200,
    parameter int LINE_LEN  = 100,
    parameter int LEN_W     = $clog2(LINE_LEN + 1),
    parameter int ROW_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         unit_reset,
    output logic                         unit_en,
    output logic [NUM_UNITS*DIGIT_W-1:0] next_battery,
    output logic [ROW_W-1:0]             rows_loaded,
    output logic                         sum_valid,
    output logic                         err
);

    localparam int WORD_W = NUM_UNITS * DIGIT_W;
    localparam logic [LEN_W-1:0] LINE_LEN_C  = LEN_W'(LINE_LEN);
    localparam logic [ROW_W-1:0] NUM_UNITS_C = ROW_W'(NUM_UNITS);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE     = ROW_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO    = LEN_W'(0);
    localparam logic [ROW_W-1:0] ROW_ZERO    = ROW_W'(0);

    feeder_state_t     state_r;
    logic [ROW_W-1:0]  row_r;
    logic [LEN_W-1:0]  col_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  step_r;
    logic              err_r;
    logic              unit_reset_r;
    logic              unit_en_r;
    logic              drive_r;
    logic              sum_valid_r;
    logic [ROW_W-1:0]  rows_loaded_r;
    logic [WORD_W-1:0] word_mask_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              parse_err_s;
    logic              close_row_s;
    logic              go_clr_s;
    logic              empty_last_s;
    logic [LEN_W-1:0]  col_cnt_s;
    logic [LEN_W-1:0]  col_nx_s;
    logic [LEN_W-1:0]  len_nx_s;
    logic [ROW_W-1:0]  row_nx_s;
    logic [LEN_W-1:0]  rd_addr_s;
    logic [WORD_W-1:0] rd_data_s;

    function automatic logic [WORD_W-1:0] lane_mask(input logic [ROW_W-1:0] rows);
        logic [WORD_W-1:0] m;
        m = {WORD_W{1'b0}};
        for (int i = 0; i < NUM_UNITS; i++) begin
            m[i*DIGIT_W +: DIGIT_W] = (ROW_W'(i) < rows) ? 4'hF : 4'h0;
        end
        return m;
    endfunction

    assign in_ready_s = !reset && ((state_r == ST_LOAD) || (state_r == ST_DONE));
    assign accept_s   = in_valid && in_ready_s;

    // Byte parser: next row/col/len, buffer write and format errors for the accepted byte
    always_comb begin
        wr_en_s     = 1'b0;
        parse_err_s = 1'b0;
        close_row_s = 1'b0;
        col_cnt_s   = col_r;
        col_nx_s    = col_r;
        len_nx_s    = len_r;
        row_nx_s    = row_r;
        if (accept_s) begin
            if (is_digit(in_data)) begin
                if (col_r == LINE_LEN_C) begin
                    parse_err_s = 1'b1;
                end else begin
                    wr_en_s   = 1'b1;
                    col_cnt_s = col_r + LEN_ONE;
                end
            end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
                parse_err_s = 1'b0;
            end else begin
                parse_err_s = 1'b1;
            end
            // A partial row still counts when the batch ends on it
            close_row_s = ((in_data == CH_LF) || in_last) && (col_cnt_s != LEN_ZERO);
            if (close_row_s) begin
                if (row_r == ROW_ZERO) begin
                    len_nx_s = col_cnt_s;
                end else begin
                    len_nx_s    = len_r;
                    parse_err_s = parse_err_s || (col_cnt_s != len_r);
                end
                row_nx_s = row_r + ROW_ONE;
                col_nx_s = LEN_ZERO;
            end else begin
                row_nx_s = row_r;
                col_nx_s = col_cnt_s;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign go_clr_s     = accept_s && ((row_nx_s == NUM_UNITS_C) || (in_last && (row_nx_s != ROW_ZERO)));
    assign empty_last_s = accept_s && in_last && (row_nx_s == ROW_ZERO);

    // Prefetch: CLR reads column 0, each PLAY cycle reads the column for the next step
    always_comb begin
        if (state_r == ST_PLAY) begin
            rd_addr_s = step_r + LEN_ONE;
        end else begin
            rd_addr_s = LEN_ZERO;
        end
    end

    day3_digit_buffer #(
        .NUM_UNITS (NUM_UNITS),
        .LINE_LEN  (LINE_LEN),
        .LEN_W     (LEN_W),
        .ROW_W     (ROW_W)
    ) u_buffer (
        .clock    (clock),
        .wr_en    (wr_en_s),
        .wr_col   (col_r),
        .wr_row   (row_r),
        .wr_digit (in_data[DIGIT_W-1:0]),
        .rd_addr  (rd_addr_s),
        .rd_data  (rd_data_s)
    );

    // Feeder sequencer with registered control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_LOAD;
            row_r         <= ROW_ZERO;
            col_r         <= LEN_ZERO;
            len_r         <= LEN_ZERO;
            step_r        <= LEN_ZERO;
            err_r         <= 1'b0;
            unit_reset_r  <= 1'b0;
            unit_en_r     <= 1'b0;
            drive_r       <= 1'b0;
            sum_valid_r   <= 1'b0;
            rows_loaded_r <= ROW_ZERO;
            word_mask_r   <= {WORD_W{1'b0}};
        end else begin
            case (state_r)
                ST_LOAD, ST_DONE: begin
                    if (accept_s) begin
                        sum_valid_r <= 1'b0;
                        err_r       <= err_r || parse_err_s;
                        if (go_clr_s) begin
                            state_r       <= ST_CLR;
                            unit_reset_r  <= 1'b1;
                            rows_loaded_r <= row_nx_s;
                            word_mask_r   <= lane_mask(row_nx_s);
                            row_r         <= row_nx_s;
                            col_r         <= col_nx_s;
                            len_r         <= len_nx_s;
                        end else if (empty_last_s) begin
                            state_r <= ST_LOAD;
                            row_r   <= ROW_ZERO;
                            col_r   <= LEN_ZERO;
                            len_r   <= LEN_ZERO;
                        end else begin
                            state_r <= ST_LOAD;
                            row_r   <= row_nx_s;
                            col_r   <= col_nx_s;
                            len_r   <= len_nx_s;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CLR: begin
                    unit_reset_r <= 1'b0;
                    unit_en_r    <= 1'b1;
                    drive_r      <= 1'b1;
                    step_r       <= LEN_ZERO;
                    state_r      <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (step_r == (len_r - LEN_ONE)) begin
                        drive_r <= 1'b0;
                        step_r  <= LEN_ZERO;
                        state_r <= ST_FLUSH;
                    end else begin
                        step_r <= step_r + LEN_ONE;
                    end
                end
                ST_FLUSH: begin
                    unit_en_r <= 1'b0;
                    step_r    <= LEN_ZERO;
                    state_r   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (step_r == LEN_ONE) begin
                        sum_valid_r <= 1'b1;
                        step_r      <= LEN_ZERO;
                        row_r       <= ROW_ZERO;
                        col_r       <= LEN_ZERO;
                        len_r       <= LEN_ZERO;
                        state_r     <= ST_DONE;
                    end else begin
                        step_r <= step_r + LEN_ONE;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign unit_reset   = unit_reset_r;
    assign unit_en      = unit_en_r;
    assign next_battery = drive_r ? (rd_data_s & word_mask_r) : {WORD_W{1'b0}};
    assign rows_loaded  = rows_loaded_r;
    assign sum_valid    = sum_valid_r;
    assign err          = err_r;

endmodule

// File: tb/tb_day3_bank_feeder.sv
// Directed scoreboard bench: expected lane words are queued as batches are sent and
// popped on every unit_en cycle; a behavioural max-joltage lane model forms the batch sum.
module tb_day3_bank_feeder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        unit_reset;
    logic        unit_en;
    logic [15:0] next_battery;
    logic [2:0]  rows_loaded;
    logic        sum_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] val;
        logic [15:0] care;
    } sb_t;
    sb_t sb_q[$];

    day3_bank_feeder #(
        .NUM_UNITS (4),
        .LINE_LEN  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .unit_reset   (unit_reset),
        .unit_en      (unit_en),
        .next_battery (next_battery),
        .rows_loaded  (rows_loaded),
        .sum_valid    (sum_valid),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int k = 0; k < s.len(); k++) begin
            send(s[k], last && (k == s.len() - 1));
        end
    endtask

    // Queue one expected word per step plus the all-zero flush word; '?' marks a don't-care digit
    task automatic push_rows(input string r0, input string r1, input string r2, input string r3,
                             input int nrows, input int len);
        string rs[4];
        sb_t e;
        logic [7:0] ch;
        rs[0] = r0; rs[1] = r1; rs[2] = r2; rs[3] = r3;
        for (int st = 0; st < len; st++) begin
            e.val  = 16'h0000;
            e.care = 16'hFFFF;
            for (int l = 0; l < nrows; l++) begin
                ch = rs[l][st];
                if (ch == 8'h3F) begin
                    e.care[l*4 +: 4] = 4'h0;
                end else begin
                    e.val[l*4 +: 4] = 4'(ch - 8'h30);
                end
            end
            sb_q.push_back(e);
        end
        e.val  = 16'h0000;
        e.care = 16'hFFFF;
        sb_q.push_back(e);
    endtask

    // Follow one playout from unit_reset to sum_valid; exp_sum < 0 skips the sum check
    task automatic observe(input int exp_rows, input int exp_len, input int exp_sum, input string tag);
        int n;
        int n_en;
        int gap;
        int sum;
        int hi[4];
        int best[4];
        bit hv[4];
        logic [3:0] prev[4];
        bit pv;
        sb_t e;
        n = 0;
        @(negedge clock);
        while (!unit_reset && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_unit_reset"}, {31'd0, unit_reset}, 32'd1);
        if (unit_reset !== 1'b1) return;
        chk({tag, "_rows_loaded"}, {29'd0, rows_loaded}, 32'(exp_rows));
        chk({tag, "_ready_busy"}, {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        chk({tag, "_reset_width"}, {31'd0, unit_reset}, 32'd0);
        n_en = 0;
        pv = 1'b0;
        for (int l = 0; l < 4; l++) begin
            hi[l] = 0; best[l] = 0; hv[l] = 1'b0; prev[l] = 4'd0;
        end
        while (unit_en && n_en < 40) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_next_battery"}, {16'd0, next_battery & e.care}, {16'd0, e.val});
            end
            for (int l = 0; l < 4; l++) begin
                if (pv) begin
                    if (hv[l] && (hi[l] * 10 + int'(prev[l]) > best[l])) best[l] = hi[l] * 10 + int'(prev[l]);
                    if (!hv[l] || int'(prev[l]) > hi[l]) hi[l] = int'(prev[l]);
                    hv[l] = 1'b1;
                end
                prev[l] = next_battery[l*4 +: 4];
            end
            pv = 1'b1;
            n_en++;
            @(negedge clock);
        end
        chk({tag, "_en_cycles"}, 32'(n_en), 32'(exp_len + 1));
        chk({tag, "_idle_zero"}, {16'd0, next_battery}, 32'd0);
        chk({tag, "_settle_ready"}, {31'd0, in_ready}, 32'd0);
        gap = 1;
        while (!sum_valid && gap < 10) begin
            @(negedge clock);
            gap++;
        end
        chk({tag, "_sum_valid_lat"}, 32'(gap), 32'd3);
        sum = best[0] + best[1] + best[2] + best[3];
        if (exp_sum >= 0) chk({tag, "_joltage_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_unit_en", {31'd0, unit_en}, 32'd0);
        chk("rst_unit_reset", {31'd0, unit_reset}, 32'd0);
        chk("rst_next_battery", {16'd0, next_battery}, 32'd0);
        chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rows_loaded", {29'd0, rows_loaded}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("load_in_ready", {31'd0, in_ready}, 32'd1);

        // Four full rows end the batch without in_last
        push_rows("98765432", "81111119", "23427826", "81811111", 4, 8);
        send_str("98765432\n81111119\n23427826\n81811111\n", 1'b0);
        observe(4, 8, 361, "t1");
        chk("t1_err", {31'd0, err}, 32'd0);

        // Partial final row on in_last, upper lanes masked
        push_rows("987", "811", "", "", 2, 3);
        send_str("987\n811", 1'b1);
        observe(2, 3, 179, "t2");

        // CR and blank line ignored, stray byte flagged
        push_rows("12", "34", "", "", 2, 2);
        send_str("12\r\n\n34x\n", 1'b1);
        observe(2, 2, 46, "t3");
        chk("t3_err", {31'd0, err}, 32'd1);

        // Reset during the third PLAY cycle aborts the batch
        send_str("1234\n", 1'b1);
        n = 0;
        while (!unit_en && n < 40) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        @(negedge clock);
        chk("t5_play3", {31'd0, unit_en}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_unit_en", {31'd0, unit_en}, 32'd0);
        chk("t5_next_battery", {16'd0, next_battery}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_rows_loaded", {29'd0, rows_loaded}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd0);
        sb_q.delete();
        push_rows("39", "42", "", "", 2, 2);
        send_str("39\n42", 1'b1);
        observe(2, 2, 81, "t5b");

        // Length mismatch on the second row; playout keeps the first row's length
        push_rows("123", "12?", "", "", 2, 3);
        send_str("123\n12", 1'b0);
        chk("t4_err_before", {31'd0, err}, 32'd0);
        send(8'h0A, 1'b1);
        chk("t4_err_after", {31'd0, err}, 32'd1);
        observe(2, 3, -1, "t4");

        // Byte held through CLR..SETTLE is taken only in the first DONE cycle
        push_rows("91", "19", "", "", 2, 2);
        send_str("91\n19", 1'b1);
        fork
            send(8'h35, 1'b0);
            observe(2, 2, 110, "t6");
        join
        chk("t6_sum_valid_clear", {31'd0, sum_valid}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        push_rows("57", "", "", "", 1, 2);
        send_str("7\n", 1'b1);
        observe(1, 2, 57, "t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
